alu_microcode_sequencer: RTL and testbench
==========================================

Name: alu_microcode_sequencer

Overview:
- Control-side counterpart of the datapath ALU: fetches 8-bit microinstructions from a 16-entry program ROM and drives the ALU's `op_sel`/`opcode`.
- Strobes register-load enables, latches the ALU's Z/C/O/N flags and resolves conditional branches on them.
- Sits between the program ROM and the datapath: A register, B register and ALU.

Parameters:
- PC_W, 4, program-counter width (ROM depth 2^PC_W).
- IW, 8, instruction width: opcode = instr[7:4], arg = instr[3:0].

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- run  in  1  start request, level-sensitive
- instr  in  IW  ROM data at `pc`, combinational ROM
- z_in, c_in, o_in, n_in  in  1 each  live ALU flags
- pc  out  PC_W  ROM address, registered
- op_sel  out  2  ALU operation select: 01 logic, 10 add, 11 sub, 00 idle
- alu_opcode  out  4  ALU logic-operation code
- imm  out  4  immediate value to datapath (= arg)
- a_we  out  1  load A register
- a_src  out  1  A source: 0 = ALU result, 1 = imm
- b_we  out  1  load B register from imm
- flags  out  4  registered {Z,C,O,N}
- busy  out  1  high in FETCH/EXEC
- halted  out  1  high in HALT

Behaviour:
- Reset (async, immediate, including mid-instruction):
  - state = IDLE; pc = 0; IR = 0; flags = 0.
  - `op_sel`, `alu_opcode`, `imm`, `a_we`, `a_src`, `b_we`, `busy`, `halted` all 0.
- States:
  - IDLE: `run` = 1 -> FETCH with pc = 0; otherwise stay.
  - FETCH: IR <= instr at the clock edge -> EXEC.
  - EXEC: decode IR, drive controls for exactly this one cycle, update pc and flags at the edge -> FETCH, or -> HALT for HLT.
  - HALT: `halted` = 1, pc frozen; `run` = 0 -> IDLE.
- `run` is ignored in FETCH/EXEC. The program continues until HLT.
- Throughput is 2 cycles per instruction.
- All control outputs are combinational from (state == EXEC, IR) and are 0 in every other state.
- Default pc update in EXEC: pc <= pc + 1 modulo 2^PC_W (15 -> 0 wraps silently).
- Decode (op = IR[7:4], arg = IR[3:0]):
  - 0x0 NOP: no controls.
  - 0x1 LOGIC: op_sel = 01, alu_opcode = arg, a_we = 1, a_src = 0, flags update.
  - 0x2 ADD: op_sel = 10, a_we = 1, a_src = 0, flags update.
  - 0x3 SUB: op_sel = 11, a_we = 1, a_src = 0, flags update.
  - 0x4 LDB: b_we = 1, imm = arg.
  - 0x5 LDA: a_we = 1, a_src = 1, imm = arg. Flags unchanged.
  - 0x6 JMP: pc <= arg.
  - 0x7 JZ / 0x8 JC / 0x9 JN / 0xA JO: pc <= arg if flags Z / C / N / O is set, else pc + 1.
  - 0xF HLT: pc unchanged -> HALT.
  - 0xB-0xE: treated as NOP.
- Flag update: flags <= {z_in, c_in, o_in, n_in}, sampled at the end of the EXEC cycle of LOGIC/ADD/SUB only. The ALU is combinational, so flags reflect that cycle's operands.
- Branches test the registered `flags` (from the last ALU op), never the live flag inputs.
- `alu_opcode` = 0 whenever op_sel != 01.
- LOGIC with arg = 0 or arg >= 8: still issued, and flags are updated. The ALU returns 0, so Z = 1.
- Branch target equal to the branch's own address is legal (tight loop).

Test Plan:
- Reset/idle: rst_n low mid-EXEC of an ADD -> all outputs 0 immediately, `a_we` drops the same cycle; hold run = 0 for 5 cycles -> pc stays 0, busy = 0.
- Arithmetic sequence: ROM {0x53, 0x45, 0x20, 0xF0}, run = 1 -> `b_we` pulse with imm = 5, then `a_we` with op_sel = 10 on the EXEC of instruction 2; flags = {0,0,0,0} after ADD 3+5 = 8 when the ALU returns C = 0; halted = 1 after 8 cycles.
- Conditional branch taken/not taken: SUB 5-5 (flags Z = 1) then JZ 0x9 -> pc = 9. Repeat with 5-3 -> pc = next address.
- Flag persistence: ALU op leaves Z = 1, then LDA/LDB/NOP executed -> flags still Z = 1; a following JZ is taken.
- Wrap-around: 16 NOPs from pc = 0 -> pc returns to 0 after 32 cycles, with no halt.
- Halt/re-arm: in HALT, run held high -> stays halted. Run low -> IDLE. Run high -> restarts fetch at pc = 0.

Source files
------------

// File: rtl/alu_microcode_sequencer.sv
// alu_microcode_sequencer
// Control-side sequencer for the datapath ALU. Fetches 8-bit microinstructions
// from a 16-entry combinational ROM, drives ALU and register-load controls for
// one EXEC cycle per instruction, latches ALU flags and resolves branches.
module alu_microcode_sequencer #(
    parameter int PC_W = 4,
    parameter int IW   = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            run,
    input  logic [IW-1:0]   instr,
    input  logic            z_in,
    input  logic            c_in,
    input  logic            o_in,
    input  logic            n_in,
    output logic [PC_W-1:0] pc,
    output logic [1:0]      op_sel,
    output logic [3:0]      alu_opcode,
    output logic [3:0]      imm,
    output logic            a_we,
    output logic            a_src,
    output logic            b_we,
    output logic [3:0]      flags,
    output logic            busy,
    output logic            halted
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_HALT
    } state_t;

    state_t          state;
    logic [IW-1:0]   ir;
    logic [3:0]      op;
    logic [3:0]      arg;
    logic            in_exec;
    logic            alu_issue;
    logic            take_branch;
    logic            is_halt;
    logic [PC_W-1:0] pc_next;

    assign op      = ir[IW-1 -: 4];
    assign arg     = ir[3:0];
    assign in_exec = (state == S_EXEC);

    // Decode the held instruction into this cycle's controls; everything is quiet outside EXEC
    always_comb begin
        op_sel      = 2'b00;
        alu_opcode  = 4'h0;
        imm         = 4'h0;
        a_we        = 1'b0;
        a_src       = 1'b0;
        b_we        = 1'b0;
        alu_issue   = 1'b0;
        take_branch = 1'b0;
        is_halt     = 1'b0;
        if (in_exec) begin
            case (op)
                4'h1: begin
                    op_sel     = 2'b01;
                    alu_opcode = arg;
                    a_we       = 1'b1;
                    alu_issue  = 1'b1;
                end
                4'h2: begin
                    op_sel    = 2'b10;
                    a_we      = 1'b1;
                    alu_issue = 1'b1;
                end
                4'h3: begin
                    op_sel    = 2'b11;
                    a_we      = 1'b1;
                    alu_issue = 1'b1;
                end
                4'h4: begin
                    b_we = 1'b1;
                    imm  = arg;
                end
                4'h5: begin
                    a_we  = 1'b1;
                    a_src = 1'b1;
                    imm   = arg;
                end
                4'h6: take_branch = 1'b1;
                4'h7: take_branch = flags[3];
                4'h8: take_branch = flags[2];
                4'h9: take_branch = flags[0];
                4'hA: take_branch = flags[1];
                4'hF: is_halt = 1'b1;
                default: ;
            endcase
        end
    end

    // Next program counter: hold on halt, jump on a taken branch, else step with silent wrap
    always_comb begin
        pc_next = pc + PC_W'(1);
        if (is_halt) begin
            pc_next = pc;
        end else if (take_branch) begin
            pc_next = PC_W'(arg);
        end
    end

    // Sequencer FSM: IDLE -> FETCH -> EXEC -> (FETCH | HALT) -> IDLE, with registered status
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            pc     <= '0;
            ir     <= '0;
            flags  <= 4'h0;
            busy   <= 1'b0;
            halted <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (run) begin
                        state <= S_FETCH;
                        pc    <= '0;
                        busy  <= 1'b1;
                    end
                end
                S_FETCH: begin
                    ir    <= instr;
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    pc <= pc_next;
                    if (alu_issue) begin
                        flags <= {z_in, c_in, o_in, n_in};
                    end
                    if (is_halt) begin
                        state  <= S_HALT;
                        busy   <= 1'b0;
                        halted <= 1'b1;
                    end else begin
                        state <= S_FETCH;
                    end
                end
                S_HALT: begin
                    if (!run) begin
                        state  <= S_IDLE;
                        halted <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_microcode_sequencer.sv
// tb_alu_microcode_sequencer
// Scoreboarded bench: an instruction-level interpreter predicts every EXEC
// cycle's controls; a monitor pops and compares as the sequencer executes.
// A small A/B/ALU environment closes the loop so the live flags are real.
module tb_alu_microcode_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       run = 1'b0;
    logic [7:0] instr;
    logic       z_in, c_in, o_in, n_in;
    logic [3:0] pc;
    logic [1:0] op_sel;
    logic [3:0] alu_opcode;
    logic [3:0] imm;
    logic       a_we, a_src, b_we;
    logic [3:0] flags;
    logic       busy, halted;

    int compared = 0;
    int mismatched = 0;

    typedef struct {
        logic [3:0] pc;
        logic [1:0] op_sel;
        logic [3:0] alu_opcode;
        logic [3:0] imm;
        logic       a_we;
        logic       a_src;
        logic       b_we;
        logic [3:0] flags;
    } exec_t;

    exec_t      q[$];
    logic [7:0] rom [16];
    logic [7:0] env_a, env_b;
    logic [3:0] noise = 4'h0;
    logic [11:0] live;
    logic [7:0] m_a, m_b;
    logic [3:0] m_flags;

    alu_microcode_sequencer #(.PC_W(4), .IW(8)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .instr(instr),
        .z_in(z_in), .c_in(c_in), .o_in(o_in), .n_in(n_in),
        .pc(pc), .op_sel(op_sel), .alu_opcode(alu_opcode), .imm(imm),
        .a_we(a_we), .a_src(a_src), .b_we(b_we), .flags(flags),
        .busy(busy), .halted(halted)
    );

    always #5 clk = ~clk;

    // 8-bit ALU used by both the environment and the reference model: returns {result, Z, C, O, N}
    function automatic logic [11:0] alu_fn(input logic [1:0] sel, input logic [3:0] opc,
                                           input logic [7:0] a, input logic [7:0] b);
        logic [8:0] wide;
        logic [7:0] r;
        logic       c, o;
        r = 8'h00; c = 1'b0; o = 1'b0; wide = 9'h000;
        case (sel)
            2'b01: begin
                case (opc)
                    4'd1: r = a & b;
                    4'd2: r = a | b;
                    4'd3: r = a ^ b;
                    4'd4: r = ~a;
                    4'd5: r = a;
                    4'd6: r = b;
                    4'd7: r = ~(a & b);
                    default: r = 8'h00;
                endcase
            end
            2'b10: begin
                wide = {1'b0, a} + {1'b0, b};
                r = wide[7:0];
                c = wide[8];
                o = (a[7] == b[7]) && (r[7] != a[7]);
            end
            2'b11: begin
                r = a - b;
                c = (a < b);
                o = (a[7] != b[7]) && (r[7] != a[7]);
            end
            default: r = 8'h00;
        endcase
        return {r, (r == 8'h00), c, o, r[7]};
    endfunction

    // Environment: combinational ROM, ALU with live flags (noise when the ALU is idle), A/B registers
    assign instr = rom[pc];
    assign live  = alu_fn(op_sel, alu_opcode, env_a, env_b);
    assign {z_in, c_in, o_in, n_in} = (op_sel == 2'b00) ? noise : live[3:0];

    always @(negedge clk) noise <= 4'($urandom);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            env_a <= 8'h00;
            env_b <= 8'h00;
        end else begin
            if (a_we) env_a <= a_src ? {4'h0, imm} : live[11:4];
            if (b_we) env_b <= {4'h0, imm};
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Interpret the ROM instruction by instruction, queueing the expected EXEC-cycle view
    task automatic runModel(input int max_steps, output bit halts, output int steps,
                            output logic [3:0] end_pc);
        exec_t       r;
        logic [3:0]  p, nxt, op, arg;
        logic [7:0]  ins;
        logic [11:0] res;
        halts = 1'b0;
        steps = 0;
        p = 4'h0;
        for (int s = 0; s < max_steps; s++) begin
            ins = rom[p];
            op  = ins[7:4];
            arg = ins[3:0];
            r = '{default: '0};
            r.pc = p;
            r.flags = m_flags;
            nxt = p + 4'd1;
            case (op)
                4'h1, 4'h2, 4'h3: begin
                    r.op_sel = op[1:0];
                    r.alu_opcode = (op == 4'h1) ? arg : 4'h0;
                    r.a_we = 1'b1;
                    res = alu_fn(r.op_sel, r.alu_opcode, m_a, m_b);
                    m_a = res[11:4];
                    m_flags = res[3:0];
                end
                4'h4: begin r.b_we = 1'b1; r.imm = arg; m_b = {4'h0, arg}; end
                4'h5: begin r.a_we = 1'b1; r.a_src = 1'b1; r.imm = arg; m_a = {4'h0, arg}; end
                4'h6: nxt = arg;
                4'h7: if (m_flags[3]) nxt = arg;
                4'h8: if (m_flags[2]) nxt = arg;
                4'h9: if (m_flags[0]) nxt = arg;
                4'hA: if (m_flags[1]) nxt = arg;
                4'hF: halts = 1'b1;
                default: ;
            endcase
            q.push_back(r);
            steps = s + 1;
            if (halts) break;
            p = nxt;
        end
        end_pc = p;
    endtask

    task automatic applyReset();
        rst_n = 1'b0;
        run = 1'b0;
        q.delete();
        m_a = 8'h00; m_b = 8'h00; m_flags = 4'h0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic loadRom(input logic [7:0] fill, input logic [7:0] p0, input logic [7:0] p1,
                           input logic [7:0] p2, input logic [7:0] p3, input logic [7:0] p4);
        for (int i = 0; i < 16; i++) rom[i] = fill;
        rom[0] = p0; rom[1] = p1; rom[2] = p2; rom[3] = p3; rom[4] = p4;
    endtask

    // Launch the program with run high and wait (bounded) for halt or for the prediction to drain
    task automatic applyStimulus(input int max_steps, input string tag);
        bit         halts;
        int         steps, cycles, limit;
        logic [3:0] end_pc;
        runModel(max_steps, halts, steps, end_pc);
        limit = 2 * max_steps + 8;
        cycles = 0;
        @(negedge clk);
        run = 1'b1;
        if (halts) begin
            do begin
                @(posedge clk);
                #1;
                cycles++;
            end while (!halted && cycles < limit);
            checkOutput({tag, "_halt_cycles"}, cycles, 1 + 2 * steps);
            checkOutput({tag, "_halt_pc"}, pc, end_pc);
            checkOutput({tag, "_halt_flags"}, flags, m_flags);
            checkOutput({tag, "_halt_busy"}, busy, 0);
            checkOutput({tag, "_drained"}, q.size(), 0);
        end else begin
            while (q.size() != 0 && cycles < limit) begin
                @(posedge clk);
                cycles++;
            end
            #1;
            checkOutput({tag, "_drained"}, q.size(), 0);
            checkOutput({tag, "_pc"}, pc, end_pc);
            checkOutput({tag, "_no_halt"}, halted, 0);
        end
        q.delete();
    endtask

    // Monitor: track FETCH/EXEC phase from busy and compare each EXEC against the scoreboard
    initial begin : monitor
        bit    phase;
        exec_t e;
        phase = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                phase = 1'b0;
            end else if (busy && phase) begin
                if (q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL exec_unexpected: pc 0x%0h executed, none predicted", pc);
                end else begin
                    e = q.pop_front();
                    checkOutput("exec_pc", pc, e.pc);
                    checkOutput("exec_op_sel", op_sel, e.op_sel);
                    checkOutput("exec_alu_opcode", alu_opcode, e.alu_opcode);
                    checkOutput("exec_imm", imm, e.imm);
                    checkOutput("exec_we", {a_we, a_src, b_we}, {e.a_we, e.a_src, e.b_we});
                    checkOutput("exec_flags", flags, e.flags);
                end
                phase = 1'b0;
            end else begin
                checkOutput(busy ? "fetch_ctrl_quiet" : "idle_ctrl_quiet",
                            {op_sel, alu_opcode, imm, a_we, a_src, b_we}, 0);
                phase = busy;
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        loadRom(8'hF0, 8'h53, 8'h45, 8'h20, 8'hF0, 8'hF0);
        applyReset();
        #1;
        checkOutput("reset_outputs",
                    {pc, op_sel, alu_opcode, imm, a_we, a_src, b_we, flags, busy, halted}, 0);

        // Reset asserted during the EXEC of the ADD
        begin
            bit         h;
            int         st;
            logic [3:0] ep;
            runModel(3, h, st, ep);
            @(negedge clk);
            run = 1'b1;
            repeat (6) @(posedge clk);
            #2;
            checkOutput("mid_add_a_we", a_we, 1);
            checkOutput("mid_add_op_sel", op_sel, 2'b10);
            rst_n = 1'b0;
            #1;
            checkOutput("mid_add_reset_outputs",
                        {pc, op_sel, alu_opcode, imm, a_we, a_src, b_we, flags, busy, halted}, 0);
            q.delete();
            run = 1'b0;
            m_a = 8'h00; m_b = 8'h00; m_flags = 4'h0;
            @(negedge clk);
            rst_n = 1'b1;
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                checkOutput("idle_hold_pc", pc, 0);
                checkOutput("idle_hold_busy", busy, 0);
            end
        end

        // Arithmetic program, then halt hold and re-arm
        applyReset();
        applyStimulus(16, "arith");
        checkOutput("arith_flags_zero", flags, 4'h0);
        checkOutput("arith_pc", pc, 3);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("halt_hold_halted", halted, 1);
        checkOutput("halt_hold_pc", pc, 3);
        @(negedge clk);
        run = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("rearm_idle_status", {busy, halted}, 2'b00);
        applyStimulus(16, "rearm");

        // Conditional branch taken and not taken
        applyReset();
        loadRom(8'hF0, 8'h55, 8'h45, 8'h30, 8'h79, 8'hF0);
        applyStimulus(16, "jz_taken");
        checkOutput("jz_taken_target", pc, 9);
        applyReset();
        loadRom(8'hF0, 8'h55, 8'h43, 8'h30, 8'h79, 8'hF0);
        applyStimulus(16, "jz_not_taken");
        checkOutput("jz_not_taken_target", pc, 4);

        // Flag persistence across LDA/LDB/NOP
        applyReset();
        loadRom(8'hF0, 8'h55, 8'h45, 8'h30, 8'h57, 8'h42);
        rom[5] = 8'h00; rom[6] = 8'h7A;
        applyStimulus(16, "persist");
        checkOutput("persist_target", pc, 10);

        // LOGIC with an out-of-range code zeroes the result and sets Z
        applyReset();
        loadRom(8'hF0, 8'h55, 8'h43, 8'h19, 8'h76, 8'hF0);
        applyStimulus(16, "logic_z");
        checkOutput("logic_z_target", pc, 6);

        // Wrap-around through sixteen NOPs, and a tight self-loop
        applyReset();
        loadRom(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        applyStimulus(16, "wrap");
        checkOutput("wrap_pc_zero", pc, 0);
        applyReset();
        loadRom(8'hF0, 8'h60, 8'hF0, 8'hF0, 8'hF0, 8'hF0);
        applyStimulus(6, "tight_loop");

        // Randomized programs
        for (int t = 0; t < 25; t++) begin
            applyReset();
            for (int i = 0; i < 16; i++) rom[i] = 8'($urandom);
            applyStimulus(40, "rand");
        end

        applyReset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
